// File: rtl/ajuste_dias_ctrl_if.sv
// Pushbutton inputs and edit/step outputs of the day-of-week edit controller.
interface ajuste_dias_ctrl_if;
    logic btn_edit;
    logic btn_up;
    logic btn_down;
    logic endd;
    logic upd;
    logic downd;

    modport master (output btn_edit, btn_up, btn_down, input endd, upd, downd);
    modport slave  (input btn_edit, btn_up, btn_down, output endd, upd, downd);
endinterface

// File: rtl/ajuste_dias_ctrl.sv
// Edit-control stage for the day-of-week counter: button sync/debounce, edit toggle,
// and single-cycle up/down step pulses with hold-to-auto-repeat.

module ajuste_dias_deb #(
    parameter int          CNT_W      = 26,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clkd,
    input  logic resetd,
    input  logic raw,
    output logic db
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // db flips only after sync has disagreed with it for DEB_CYCLES consecutive edges
    always_ff @(posedge clkd or posedge resetd) begin
        if (resetd) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                db  <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ajuste_dias_ctrl #(
    parameter int          CNT_W         = 26,
    parameter int unsigned DEB_CYCLES    = 1_000_000,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 20_000_000
) (
    input logic               clkd,
    input logic               resetd,
    ajuste_dias_ctrl_if.slave bus
);
    localparam int NUM_BTN = 3;  // 0 edit, 1 up, 2 down
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

    logic [NUM_BTN-1:0] raw, db, db_q, rise;
    logic               endd_q, endd_nxt, up_q, dn_q, dir, held;
    logic [CNT_W-1:0]   timer, t_last;
    state_t             state;

    assign raw = {bus.btn_down, bus.btn_up, bus.btn_edit};

    ajuste_dias_deb #(.CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
        .clkd   (clkd),
        .resetd (resetd),
        .raw    (raw),
        .db     (db)
    );

    assign rise     = db & ~db_q;
    // Step decisions use the edit level being registered this edge so a pulse never
    // coincides with endd low.
    assign endd_nxt = endd_q ^ rise[0];
    assign held     = dir ? db[2] : db[1];
    assign t_last   = (state == HOLD) ? HOLD_LAST : RPT_LAST;

    always_ff @(posedge clkd or posedge resetd) begin
        if (resetd) begin
            db_q   <= '0;
            endd_q <= 1'b0;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
            dir    <= 1'b0;
            timer  <= '0;
            state  <= IDLE;
        end else begin
            db_q   <= db;
            endd_q <= endd_nxt;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
            case (state)
                IDLE: begin
                    // A rise with the other button already down (or rising too) is ignored.
                    if (endd_nxt && rise[1] && !db[2]) begin
                        up_q  <= 1'b1;
                        dir   <= 1'b0;
                        timer <= '0;
                        state <= HOLD;
                    end else if (endd_nxt && rise[2] && !db[1]) begin
                        dn_q  <= 1'b1;
                        dir   <= 1'b1;
                        timer <= '0;
                        state <= HOLD;
                    end
                end
                HOLD, RPT: begin
                    if (!endd_nxt || !held) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (timer == t_last) begin
                        up_q  <= ~dir;
                        dn_q  <= dir;
                        timer <= '0;
                        state <= RPT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.endd  = endd_q;
    assign bus.upd   = up_q;
    assign bus.downd = dn_q;
endmodule

// File: tb/tb_ajuste_dias_ctrl.sv
// Bench for ajuste_dias_ctrl: directed segment table, reset corner case, random soak vs model.
module tb_ajuste_dias_ctrl;
    localparam int DEB = 4, HOLDC = 10, RPTC = 3;

    logic clkd = 1'b0;
    logic resetd;
    ajuste_dias_ctrl_if bus();

    ajuste_dias_ctrl #(.CNT_W(8), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLDC), .REPEAT_CYCLES(RPTC)) dut (
        .clkd   (clkd),
        .resetd (resetd),
        .bus    (bus)
    );

    always #5 clkd = ~clkd;

    int errors = 0, checks = 0, cyc = 0;
    int n_up, n_dn, rel, first, tog;
    logic prev_endd;

    // Reference model: per-button raw history, debounced level, and "age since first pulse".
    int m_raw1[3], m_raw2[3], m_run[3];
    bit m_db[3], m_dbp[3];
    bit m_endd, m_up, m_dn, m_act;
    int m_btn, m_age;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_raw1[i] = 0; m_raw2[i] = 0; m_run[i] = 0; m_db[i] = 0; m_dbp[i] = 0;
        end
        m_endd = 0; m_up = 0; m_dn = 0; m_act = 0; m_btn = 1; m_age = 0;
    endfunction

    function automatic void model_edge();
        bit rise[3];
        bit en, pulse;
        int rawv[3];
        int oth;
        rawv[0] = int'(bus.btn_edit); rawv[1] = int'(bus.btn_up); rawv[2] = int'(bus.btn_down);
        for (int i = 0; i < 3; i++) rise[i] = m_db[i] && !m_dbp[i];
        en = m_endd ^ rise[0];
        pulse = 0;
        if (m_act) begin
            if (!en || !m_db[m_btn]) m_act = 0;
            else begin
                m_age++;
                pulse = (m_age == HOLDC) || (m_age > HOLDC && (m_age - HOLDC) % RPTC == 0);
            end
        end else if (en) begin
            for (int b = 1; b <= 2; b++) begin
                oth = 3 - b;
                if (!pulse && rise[b] && !m_db[oth]) begin
                    pulse = 1; m_act = 1; m_btn = b; m_age = 0;
                end
            end
        end
        m_endd = en;
        m_up = pulse && m_btn == 1;
        m_dn = pulse && m_btn == 2;
        for (int i = 0; i < 3; i++) begin
            m_dbp[i] = m_db[i];
            if ((m_raw2[i] != 0) != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_db[i] = !m_db[i];
                    m_run[i] = 0;
                end
            end else m_run[i] = 0;
            m_raw2[i] = m_raw1[i];
            m_raw1[i] = rawv[i];
        end
    endfunction

    task automatic tick();
        @(posedge clkd);
        model_edge();
        #1;
        cyc++; rel++;
        chk("outs{endd,upd,downd}", int'({bus.endd, bus.upd, bus.downd}), int'({m_endd, m_up, m_dn}));
        n_up += int'(bus.upd);
        n_dn += int'(bus.downd);
        if ((bus.upd || bus.downd) && first == 0) first = rel;
        if (bus.endd != prev_endd && tog == 0) tog = rel;
        prev_endd = bus.endd;
    endtask

    task automatic run(input logic e, input logic u, input logic d, input int n);
        bus.btn_edit = e; bus.btn_up = u; bus.btn_down = d;
        n_up = 0; n_dn = 0; rel = 0; first = 0; tog = 0; prev_endd = bus.endd;
        repeat (n) tick();
    endtask

    typedef struct { int e, u, d, n, up, dn, endd, first, tog; } vec_t;
    vec_t tbl[23];

    int dur[3];
    logic val[3];

    initial begin
        //          e  u  d   n  up dn endd first tog
        tbl[0]  = '{0, 1, 0, 20, 0, 0, 0, 0, 0};   // up ignored while not editing
        tbl[1]  = '{0, 0, 0, 12, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 10, 0, 0, 1, 0, 7};   // edit on at edge 7
        tbl[3]  = '{0, 0, 0, 12, 0, 0, 1, 0, 0};   // edit release: no effect
        tbl[4]  = '{0, 1, 0, 40, 9, 0, 1, 7, 0};   // 7,17,20..38
        tbl[5]  = '{0, 0, 0, 20, 2, 0, 1, 1, 0};   // repeats until db drops
        tbl[6]  = '{0, 0, 1,  1, 0, 0, 1, 0, 0};   // glitches
        tbl[7]  = '{0, 0, 0,  6, 0, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 1,  2, 0, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 0,  6, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 1,  3, 0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0,  6, 0, 0, 1, 0, 0};
        tbl[12] = '{0, 0, 1,  5, 0, 0, 1, 0, 0};   // 5-cycle press
        tbl[13] = '{0, 0, 0, 15, 0, 1, 1, 2, 0};   // ...its single pulse
        tbl[14] = '{0, 1, 1, 20, 0, 0, 1, 0, 0};   // simultaneous rise
        tbl[15] = '{0, 0, 1, 20, 0, 0, 1, 0, 0};   // up released, down still held
        tbl[16] = '{0, 0, 0, 15, 0, 0, 1, 0, 0};
        tbl[17] = '{0, 0, 1,  8, 0, 1, 1, 7, 0};   // re-press pulses
        tbl[18] = '{0, 0, 0, 15, 0, 0, 1, 0, 0};
        tbl[19] = '{0, 0, 1, 30, 0, 6, 1, 7, 0};   // into repeat
        tbl[20] = '{1, 0, 1, 10, 0, 2, 0, 2, 7};   // edit off mid-repeat
        tbl[21] = '{0, 0, 1, 10, 0, 0, 0, 0, 0};
        tbl[22] = '{0, 0, 0, 15, 0, 0, 0, 0, 0};

        resetd = 1'b1;
        bus.btn_edit = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        model_reset();
        repeat (3) @(posedge clkd);
        #1;
        chk("reset_outs", int'({bus.endd, bus.upd, bus.downd}), 0);
        @(negedge clkd);
        resetd = 1'b0;

        for (int i = 0; i < 23; i++) begin
            run(tbl[i].e != 0, tbl[i].u != 0, tbl[i].d != 0, tbl[i].n);
            chk($sformatf("row%0d_up_count", i), n_up, tbl[i].up);
            chk($sformatf("row%0d_down_count", i), n_dn, tbl[i].dn);
            chk($sformatf("row%0d_endd", i), int'(bus.endd), tbl[i].endd);
            chk($sformatf("row%0d_first_pulse_edge", i), first, tbl[i].first);
            chk($sformatf("row%0d_endd_toggle_edge", i), tog, tbl[i].tog);
        end

        // Reset during auto-repeat, then a still-held button must not pulse.
        run(1, 0, 0, 10);
        run(0, 0, 0, 12);
        chk("rst_pre_endd", int'(bus.endd), 1);
        run(0, 1, 0, 23);
        chk("rst_pre_up_count", n_up, 4);
        chk("rst_pre_upd_now", int'(bus.upd), 1);
        #2 resetd = 1'b1;
        #1;
        chk("rst_async_outs", int'({bus.endd, bus.upd, bus.downd}), 0);
        model_reset();
        repeat (2) @(posedge clkd);
        @(negedge clkd);
        resetd = 1'b0;
        run(0, 1, 0, 20);
        chk("rst_post_held_up", n_up, 0);
        run(1, 1, 0, 10);
        run(0, 1, 0, 12);
        chk("rst_post_edit_endd", int'(bus.endd), 1);
        chk("rst_post_edit_held_up", n_up, 0);
        run(0, 0, 0, 12);
        run(0, 1, 0, 10);
        chk("rst_repress_up", n_up, 1);
        run(0, 0, 0, 12);

        // Random soak against the model.
        for (int i = 0; i < 3; i++) begin dur[i] = 0; val[i] = 1'b0; end
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (dur[i] == 0) begin
                    val[i] = ($urandom_range(0, 1) == 1);
                    if (i == 0) dur[i] = val[i] ? $urandom_range(1, 30) : $urandom_range(10, 80);
                    else dur[i] = $urandom_range(1, 30);
                end
                dur[i]--;
            end
            run(val[0], val[1], val[2], 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
